// File: rtl/scroller_pkg.sv
// Shared constants, band table and FSM state type for the parallax scroll sequencer.
package scroller_pkg;

    localparam int unsigned LAYERS_DEF      = 4;
    localparam int unsigned LINE_EVT_H_DEF  = 656;
    localparam int unsigned FRAME_EVT_V_DEF = 481;

    localparam int unsigned POS_W      = 10;
    localparam int unsigned CUT_W      = 5;
    localparam int unsigned BAND_SHIFT = 4;
    localparam int unsigned MAX_CUTOFF = 16;

    localparam int unsigned BASE_N     = 4;
    localparam int unsigned BASE_IDX_W = 2;
    localparam int unsigned BASE_STEP  = 48;
    localparam logic [POS_W-1:0] BASE_TABLE [BASE_N] = '{10'd128, 10'd176, 10'd224, 10'd272};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_UPD  = 1'b1
    } seq_state_e;

    // Layers beyond the table continue the same 48-line spacing.
    function automatic logic [POS_W-1:0] base_for(input int unsigned k);
        if (k < BASE_N) begin
            return BASE_TABLE[BASE_IDX_W'(k)];
        end
        return POS_W'(int'(BASE_TABLE[BASE_N-1]) + int'(BASE_STEP * (k - (BASE_N - 1))));
    endfunction

endpackage

// File: rtl/band_cutoff.sv
// Skyline cutoff for one layer: number of 16-line bands below vcount, clamped.
module band_cutoff
    import scroller_pkg::*;
#(
    parameter logic [POS_W-1:0] BASE = 10'd128
) (
    input  logic [POS_W-1:0] vcount,
    output logic [CUT_W-1:0] cutoff_c
);

    localparam int unsigned BAND_W = POS_W - BAND_SHIFT;

    logic [POS_W-1:0]  offset;
    logic [BAND_W-1:0] band;

    always_comb begin
        offset = vcount - BASE;
        band   = offset[POS_W-1:BAND_SHIFT];
        if (vcount < BASE) begin
            cutoff_c = '0;
        end else if (band >= BAND_W'(MAX_CUTOFF - 1)) begin
            cutoff_c = CUT_W'(MAX_CUTOFF);
        end else begin
            cutoff_c = CUT_W'(band) + CUT_W'(1);
        end
    end

endmodule

// File: rtl/scroll_sequencer.sv
// Per-line reload strobe, skyline cutoffs and per-frame layer divider sequencing.
module scroll_sequencer
    import scroller_pkg::*;
#(
    parameter int unsigned LAYERS      = LAYERS_DEF,
    parameter int unsigned LINE_EVT_H  = LINE_EVT_H_DEF,
    parameter int unsigned FRAME_EVT_V = FRAME_EVT_V_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [POS_W-1:0]          hcount,
    input  logic [POS_W-1:0]          vcount,
    input  logic                      pause,
    output logic                      line_load,
    output logic [LAYERS-1:0]         frame_adv,
    output logic [CUT_W*LAYERS-1:0]   cutoff,
    output logic                      busy
);

    localparam int unsigned IDX_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam int unsigned DIV_W = (LAYERS > 1) ? LAYERS - 1 : 1;

    seq_state_e              state_q;
    seq_state_e              state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [DIV_W-1:0]        div_q [LAYERS];
    logic [DIV_W-1:0]        div_d [LAYERS];
    logic [LAYERS-1:0]       frame_adv_d;
    logic [CUT_W*LAYERS-1:0] cutoff_c;
    logic                    line_evt_c;
    logic                    frame_evt_c;
    logic                    last_layer_c;

    assign line_evt_c   = (hcount == POS_W'(LINE_EVT_H));
    assign frame_evt_c  = line_evt_c && (vcount == POS_W'(FRAME_EVT_V));
    assign last_layer_c = (idx_q == IDX_W'(LAYERS - 1));

    for (genvar k = 0; k < LAYERS; k++) begin : g_band
        band_cutoff #(
            .BASE (base_for(k))
        ) u_band_cutoff (
            .vcount   (vcount),
            .cutoff_c (cutoff_c[CUT_W*k +: CUT_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame event seen while already updating is deliberately dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (frame_evt_c)  state_d = ST_UPD;
            ST_UPD:  if (last_layer_c) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // One layer per UPD cycle; pause is sampled in that layer's own cycle.
    always_comb begin
        idx_d       = idx_q;
        div_d       = div_q;
        frame_adv_d = '0;
        if (state_q == ST_UPD) begin
            idx_d = last_layer_c ? '0 : idx_q + IDX_W'(1);
            for (int unsigned k = 0; k < LAYERS; k++) begin
                if ((idx_q == IDX_W'(k)) && !pause) begin
                    if (div_q[k] == DIV_W'((1 << k) - 1)) begin
                        div_d[k]       = '0;
                        frame_adv_d[k] = 1'b1;
                    end else begin
                        div_d[k] = div_q[k] + DIV_W'(1);
                    end
                end
            end
        end else begin
            idx_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            frame_adv <= '0;
            line_load <= 1'b0;
            cutoff    <= '0;
            busy      <= 1'b0;
            for (int unsigned k = 0; k < LAYERS; k++) begin
                div_q[k] <= '0;
            end
        end else begin
            idx_q     <= idx_d;
            div_q     <= div_d;
            frame_adv <= frame_adv_d;
            line_load <= line_evt_c;
            busy      <= (state_d == ST_UPD);
            if (line_evt_c) begin
                cutoff <= cutoff_c;
            end
        end
    end

endmodule

// File: tb/tb_scroll_sequencer.sv
// Scoreboard bench for scroll_sequencer: line strobes, cutoffs, divider pulses, reset.
module tb_scroll_sequencer;

    localparam int LAYERS = 4;

    typedef struct {
        int          due;
        logic [19:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        pause;
    logic        line_load;
    logic [3:0]  frame_adv;
    logic [19:0] cutoff;
    logic        busy;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   evals [LAYERS];
    int   adv_cnt [LAYERS];
    int   snap [LAYERS];
    exp_t line_q [$];
    exp_t adv_q [$];

    scroll_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .pause     (pause),
        .line_load (line_load),
        .frame_adv (frame_adv),
        .cutoff    (cutoff),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [19:0] exp_cutoff(input int v);
        logic [19:0] r;
        int          base;
        int          c;
        r = '0;
        for (int k = 0; k < LAYERS; k++) begin
            base = 128 + 48 * k;
            if (v < base) c = 0;
            else c = (v - base) / 16 + 1;
            if (c > 16) c = 16;
            r[5*k +: 5] = 5'(c);
        end
        return r;
    endfunction

    task automatic push_line(input int due, input logic [19:0] val);
        exp_t e;
        e.due = due;
        e.val = val;
        line_q.push_back(e);
    endtask

    task automatic push_adv(input int due, input logic [19:0] val);
        exp_t e;
        e.due = due;
        e.val = val;
        adv_q.push_back(e);
    endtask

    // Scoreboard consumer: every strobe the DUT emits must match a queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (line_load) begin
                if (line_q.size() == 0) begin
                    chk("line_load_unexpected", 32'd1, 32'd0);
                end else begin
                    e = line_q.pop_front();
                    chk("line_load_cycle", cyc, e.due);
                    chk("cutoff", 32'(cutoff), 32'(e.val));
                end
            end
            if (frame_adv != 4'd0) begin
                chk("adv_onehot", 32'($countones(frame_adv)), 32'd1);
                for (int k = 0; k < LAYERS; k++) if (frame_adv[k]) adv_cnt[k]++;
                if (adv_q.size() == 0) begin
                    chk("adv_unexpected", 32'(frame_adv), 32'd0);
                end else begin
                    e = adv_q.pop_front();
                    chk("adv_cycle", cyc, e.due);
                    chk("adv_bits", 32'(frame_adv), 32'(e.val));
                end
            end
        end
    end

    task automatic line_event(input int v);
        logic [19:0] c;
        @(posedge clk); #1;
        hcount = 10'd656;
        vcount = 10'(v);
        c = exp_cutoff(v);
        push_line(cyc + 1, c);
        @(posedge clk); #1;
        hcount = 10'd0;
        vcount = 10'(v + 37);
        repeat (3) @(posedge clk);
        #1;
        chk("cutoff_hold", 32'(cutoff), 32'(c));
    endtask

    // Bit k of mask holds pause high during layer k's evaluation cycle.
    task automatic frame_event(input logic [3:0] mask, input bit dbl);
        int t0;
        @(posedge clk); #1;
        t0 = cyc;
        hcount = 10'd656;
        vcount = 10'd481;
        pause  = 1'b0;
        push_line(t0 + 1, exp_cutoff(481));
        if (dbl) push_line(t0 + 3, exp_cutoff(481));
        for (int k = 0; k < LAYERS; k++) begin
            if (!mask[k]) begin
                evals[k]++;
                if (evals[k] % (1 << k) == 0) push_adv(t0 + 2 + k, 20'(1 << k));
            end
        end
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk); #1;
            hcount = (dbl && j == 2) ? 10'd656 : 10'd0;
            pause  = (j <= 4) ? mask[j-1] : 1'b0;
            if (j <= 4) chk("busy_upd", 32'(busy), 32'd1);
            else        chk("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int t0;
        int vlist [8] = '{100, 128, 143, 144, 368, 400, 176, 300};
        int want  [LAYERS] = '{8, 4, 2, 1};

        for (int k = 0; k < LAYERS; k++) begin
            evals[k]   = 0;
            adv_cnt[k] = 0;
        end
        rst_n  = 1'b0;
        hcount = 10'd0;
        vcount = 10'd0;
        pause  = 1'b0;
        #1;
        chk("rst_line_load", 32'(line_load), 32'd0);
        chk("rst_frame_adv", 32'(frame_adv), 32'd0);
        chk("rst_cutoff", 32'(cutoff), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vlist[i]) line_event(vlist[i]);

        for (int k = 0; k < LAYERS; k++) snap[k] = adv_cnt[k];
        repeat (8) frame_event(4'h0, 1'b0);
        for (int k = 0; k < LAYERS; k++) chk($sformatf("adv_count_l%0d", k), adv_cnt[k] - snap[k], want[k]);

        frame_event(4'h0, 1'b0);
        frame_event(4'h0, 1'b0);
        frame_event(4'hF, 1'b0);
        frame_event(4'hF, 1'b0);
        repeat (4) frame_event(4'h0, 1'b0);
        frame_event(4'b1010, 1'b0);
        frame_event(4'h0, 1'b0);

        frame_event(4'h0, 1'b1);
        repeat (3) @(posedge clk);

        // Reset during the update sequence, at T+2.
        @(posedge clk); #1;
        t0 = cyc;
        hcount = 10'd656;
        vcount = 10'd481;
        push_line(t0 + 1, exp_cutoff(481));
        @(posedge clk); #1;
        hcount = 10'd0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_frame_adv", 32'(frame_adv), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_line_load", 32'(line_load), 32'd0);
        chk("midrst_cutoff", 32'(cutoff), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_busy_hold", 32'(busy), 32'd0);
        chk("midrst_adv_hold", 32'(frame_adv), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < LAYERS; k++) evals[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        frame_event(4'h0, 1'b0);
        frame_event(4'h0, 1'b0);
        frame_event(4'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        chk("line_q_empty", line_q.size(), 32'd0);
        chk("adv_q_empty", adv_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scroll_sequencer.md
SCROLL_SEQUENCER -- requirements
Module: scroll_sequencer

Interface
REQ-001 SHALL have parameter LAYERS, default 4, number of parallax layers sequenced.
REQ-002 SHALL have parameter LINE_EVT_H, default 656, hcount value marking the per-line event.
REQ-003 SHALL have parameter FRAME_EVT_V, default 481, vcount value that, with LINE_EVT_H, marks the per-frame event.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port hcount, input, 10, horizontal position from the sync generator.
REQ-007 SHALL have port vcount, input, 10, vertical position from the sync generator.
REQ-008 SHALL have port pause, input, 1, freezes all layer scrolling while high.
REQ-009 SHALL have port line_load, output, 1, one-cycle strobe: layer engines reload line LFSRs from frame-start copies.
REQ-010 SHALL have port frame_adv, output, LAYERS, per-layer one-cycle strobe: advance that layer's frame-start LFSR one step.
REQ-011 SHALL have port cutoff, output, 5*LAYERS, packed per-layer skyline cutoff, layer k in bits [5k+4:5k].
REQ-012 SHALL have port busy, output, 1, high while the frame update sequence runs.

Function
REQ-013 SHALL define event cycle T as any cycle where hcount == LINE_EVT_H; frame event additionally requires vcount == FRAME_EVT_V.
REQ-014 SHALL assert line_load for exactly cycle T+1 on every line event, including the frame-event line.
REQ-015 SHALL register cutoff at T+1 as: cutoff_k = 0 if vcount < BASE_k, else min(16, ((vcount - BASE_k) >> 4) + 1); BASE = {128, 176, 224, 272}.
REQ-016 SHALL hold cutoff constant between line events.
REQ-017 SHALL implement FSM states IDLE and UPD with a layer index idx (2 bits for LAYERS=4).
REQ-018 SHALL move IDLE->UPD at T+1 on a frame event with idx=0; busy high exactly while in UPD.
REQ-019 SHALL, in UPD cycle T+1+k, evaluate layer k only: if pause low, increment its divider div_k; if div_k equals 2^k - 1, clear it and assert frame_adv[k] in cycle T+2+k.
REQ-020 SHALL hold div_k and assert no frame_adv[k] when pause is high during layer k's evaluation cycle; pause is sampled per layer, not latched per frame.
REQ-021 SHALL return UPD->IDLE after idx == LAYERS-1 (busy high T+1..T+4 for default).
REQ-022 SHALL ignore a frame event arriving while in UPD (no restart, no extra pulses).
REQ-023 SHALL assert at most one frame_adv bit in any cycle.
REQ-024 SHALL give divider periods of 1, 2, 4, 8 frames for layers 0..3; divider widths sized to LAYERS-1 bits, wrap only via the equality clear.

Reset
REQ-025 SHALL, on rst_n low, immediately clear line_load, frame_adv, cutoff (all zero), busy, all div_k, idx, and force IDLE, regardless of clk.
REQ-026 SHALL, if reset hits mid-UPD, emit no remaining frame_adv pulses; the first sequence after release starts at the next frame event.

Structure
REQ-027 SHALL place LAYERS, LINE_EVT_H, FRAME_EVT_V defaults, BASE table, band shift (4), max cutoff (16) and the FSM state enum in package scroller_pkg.
REQ-028 SHALL instantiate sub-module band_cutoff (one per layer) computing the REQ-015 clamp combinationally from vcount and BASE_k.

Verification
REQ-029 SHALL cover: vcount 100, hcount reaches 656 -> line_load high one cycle at T+1, cutoff all 0.
REQ-030 SHALL cover: vcount 128/143/144/368/400 -> cutoff[4:0] = 1/1/2/16/16; vcount 176 -> cutoff[9:5] = 1.
REQ-031 SHALL cover: 8 consecutive frame events, pause low -> frame_adv[0] 8 pulses, [1] 4, [2] 2, [3] 1; pulses at T+2+k; busy high 4 cycles each frame.
REQ-032 SHALL cover: pause high for frames 3-4 -> div values unchanged, zero frame_adv in those frames, counts resume exactly afterwards.
REQ-033 SHALL cover: rst_n low at T+2 of a frame sequence -> frame_adv and busy drop asynchronously, no further pulses that frame.
REQ-034 SHALL cover: hcount forced to 656 with vcount 481 on two cycles T and T+2 -> only one 4-layer sequence, at most one frame_adv bit per cycle.
